// File: rtl/regfile_multiport_wb_if.sv
// ---------------------------------------------------------------------------
// regfile_multiport_wb_if
// Bus bundle between the functional-unit writeback channels, the dispatch
// read ports and the register file.
//
// Signals:
//   wb_valid     [NUM_WB]          channel i holds a result
//   wb_dest      [NUM_WB*ADDR_W]   destination of channel i, slice i*ADDR_W
//   wb_data      [NUM_WB*DATA_W]   result of channel i, slice i*DATA_W
//   wb_ready     [NUM_WB]          combinational grant for channel i
//   rd_en        [NUM_RD]          read request per port
//   rd_addr      [NUM_RD*ADDR_W]   read address per port
//   rd_data      [NUM_RD*DATA_W]   registered read data
//   rd_valid     [NUM_RD]          one-cycle pulse, rd_data valid
//   commit_count [NUM_WB*16]       per-channel saturating commit counter
//
// Modports: master = sources/dispatch side, slave = register file.
// ---------------------------------------------------------------------------
interface regfile_multiport_wb_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_WB   = 3,
  parameter int NUM_RD   = 2
);
  localparam int ADDR_W = $clog2(NUM_REGS);

  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*ADDR_W-1:0] wb_dest;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB-1:0]        wb_ready;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;
  logic [NUM_WB*16-1:0]     commit_count;

  modport master (
    output wb_valid, wb_dest, wb_data, rd_en, rd_addr,
    input  wb_ready, rd_data, rd_valid, commit_count
  );

  modport slave (
    input  wb_valid, wb_dest, wb_data, rd_en, rd_addr,
    output wb_ready, rd_data, rd_valid, commit_count
  );
endinterface

// File: rtl/regfile_multiport_wb.sv
// ---------------------------------------------------------------------------
// regfile_multiport_wb
// Register file for the out-of-order core. NUM_WB writeback channels compete
// through valid/ready handshakes; a round-robin arbiter grants up to NUM_WP
// of them per cycle, never two to the same non-zero destination. NUM_RD
// registered read ports serve dispatch. Register 0 reads as zero, addresses
// >= NUM_REGS read zero and writes to them are dropped (still acknowledged).
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      regfile_multiport_wb_if.slave (writeback, read, commit counters)
//
// Build option: define REGFILE_BYPASS_EN to forward a same-edge commit to a
// read of the same address; otherwise such a read returns the old value.
// ---------------------------------------------------------------------------
module regfile_multiport_wb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_WB   = 3,
  parameter int NUM_WP   = 1,
  parameter int NUM_RD   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  regfile_multiport_wb_if.slave  bus
);
  localparam int          ADDR_W  = $clog2(NUM_REGS);
  localparam int          PTR_W   = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] regs     [NUM_REGS];
  logic [ADDR_W-1:0] dest     [NUM_WB];
  logic [DATA_W-1:0] data     [NUM_WB];
  logic [15:0]       cnt      [NUM_WB];
  logic [ADDR_W-1:0] raddr    [NUM_RD];
  logic [DATA_W-1:0] rd_value [NUM_RD];
  logic [DATA_W-1:0] rd_q     [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_q;

  logic [PTR_W-1:0]  ptr, ptr_next;
  logic [NUM_WB-1:0] grant, ready, xfer;

  for (genvar i = 0; i < NUM_WB; i++) begin : g_wb
    assign dest[i] = bus.wb_dest[i*ADDR_W +: ADDR_W];
    assign data[i] = bus.wb_data[i*DATA_W +: DATA_W];
    assign bus.commit_count[i*16 +: 16] = cnt[i];
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign raddr[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign bus.rd_data[k*DATA_W +: DATA_W] = rd_q[k];
  end

  assign bus.rd_valid = rd_valid_q;

  // Round-robin arbiter: pass 0 visits channels ptr..NUM_WB-1, pass 1 visits
  // 0..ptr-1, so the scan starts at ptr and wraps without a runtime modulo.
  always_comb begin
    int   granted;
    int   last;
    logic conflict;
    // NOTE: every variable driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    grant    = '0;
    granted  = 0;
    last     = 0;
    conflict = 1'b0;
    ptr_next = ptr;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_WB; i++) begin
        if (((pass == 0) == (i >= int'(ptr))) && bus.wb_valid[i] && (granted < NUM_WP)) begin
          // NOTE: blocking assignments are used in combinational logic so that
          // later iterations see the grants made by earlier ones.
          conflict = 1'b0;
          // Destination 0 is never written, so it can never collide.
          if (dest[i] != '0) begin
            for (int k = 0; k < NUM_WB; k++) begin
              if (grant[k] && (dest[k] == dest[i])) conflict = 1'b1;
            end
          end
          if (!conflict) begin
            grant[i] = 1'b1;
            granted  = granted + 1;
            last     = i;
          end
        end
      end
    end
    if (granted > 0) ptr_next = (last == NUM_WB - 1) ? '0 : PTR_W'(last + 1);
  end

  // No grant may be seen while reset is held, so nothing transfers that cycle.
  assign ready        = grant & {NUM_WB{reset_n}};
  assign xfer         = bus.wb_valid & ready;
  assign bus.wb_ready = ready;

  // Read mux. Same-edge commits are forwarded only in the bypass build.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_value[k] = '0;
      if ((raddr[k] != '0) && (int'(raddr[k]) < NUM_REGS)) begin
        rd_value[k] = regs[raddr[k]];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NUM_WB; i++) begin
          if (xfer[i] && (dest[i] == raddr[k])) rd_value[k] = data[i];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the array is flop-based architectural state that must read zero
      // after reset, so every entry is cleared here rather than left as RAM.
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      for (int i = 0; i < NUM_WB; i++) cnt[i] <= '0;
      for (int k = 0; k < NUM_RD; k++) rd_q[k] <= '0;
      rd_valid_q <= '0;
      ptr        <= '0;
    end else begin
      ptr <= ptr_next;
      for (int i = 0; i < NUM_WB; i++) begin
        if (xfer[i]) begin
          if ((dest[i] != '0) && (int'(dest[i]) < NUM_REGS)) regs[dest[i]] <= data[i];
          if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 16'd1;
        end
      end
      for (int k = 0; k < NUM_RD; k++) begin
        rd_valid_q[k] <= bus.rd_en[k];
        if (bus.rd_en[k]) rd_q[k] <= rd_value[k];
      end
    end
  end
endmodule

// File: tb/tb_regfile_multiport_wb.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport_wb
// Directed bench for regfile_multiport_wb. Instance dut_a uses NUM_WP=1,
// instance dut_b uses NUM_WP=2; both share clk and reset_n. Inputs change
// 1 ns after the rising edge, combinational wb_ready is sampled on the
// falling edge, registered outputs 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_regfile_multiport_wb;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int NUM_WB   = 3;
  localparam int NUM_RD   = 2;
  localparam int ADDR_W   = $clog2(NUM_REGS);

`ifdef REGFILE_BYPASS_EN
  localparam logic [31:0] BYP_EXP = 32'h55;
`else
  localparam logic [31:0] BYP_EXP = 32'h0;
`endif

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  regfile_multiport_wb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_WB(NUM_WB), .NUM_RD(NUM_RD)) bus_a ();
  regfile_multiport_wb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_WB(NUM_WB), .NUM_RD(NUM_RD)) bus_b ();

  regfile_multiport_wb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_WB(NUM_WB), .NUM_WP(1), .NUM_RD(NUM_RD))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));

  regfile_multiport_wb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_WB(NUM_WB), .NUM_WP(2), .NUM_RD(NUM_RD))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  task automatic wb_a(input logic [NUM_WB-1:0] v, input logic [NUM_WB*ADDR_W-1:0] d,
                      input logic [NUM_WB*DATA_W-1:0] x);
    bus_a.wb_valid = v;
    bus_a.wb_dest  = d;
    bus_a.wb_data  = x;
  endtask

  task automatic wb_b(input logic [NUM_WB-1:0] v, input logic [NUM_WB*ADDR_W-1:0] d,
                      input logic [NUM_WB*DATA_W-1:0] x);
    bus_b.wb_valid = v;
    bus_b.wb_dest  = d;
    bus_b.wb_data  = x;
  endtask

  // Reads two addresses on both ports, checks data and the one-cycle rd_valid pulse.
  task automatic rd(input bit use_b, input string tag, input int a0, input int a1,
                    input logic [31:0] e0, input logic [31:0] e1);
    logic [NUM_RD*ADDR_W-1:0] addr;
    logic [NUM_RD*DATA_W-1:0] dat;
    logic [NUM_RD-1:0]        vld;
    addr = {ADDR_W'(a1), ADDR_W'(a0)};
    if (use_b) begin bus_b.rd_en = 2'b11; bus_b.rd_addr = addr; end
    else       begin bus_a.rd_en = 2'b11; bus_a.rd_addr = addr; end
    tick();
    dat = use_b ? bus_b.rd_data  : bus_a.rd_data;
    vld = use_b ? bus_b.rd_valid : bus_a.rd_valid;
    check({tag, "_vld"}, vld, 2'b11);
    check({tag, "_p0"}, dat[31:0], e0);
    check({tag, "_p1"}, dat[63:32], e1);
    bus_a.rd_en = '0;
    bus_b.rd_en = '0;
    tick();
    vld = use_b ? bus_b.rd_valid : bus_a.rd_valid;
    check({tag, "_pulse"}, vld, 2'b00);
  endtask

  initial begin
    clk     = 1'b0;
    reset_n = 1'b0;
    errors  = 0;
    checks  = 0;
    wb_a('0, '0, '0);
    wb_b('0, '0, '0);
    bus_a.rd_en = '0; bus_a.rd_addr = '0;
    bus_b.rd_en = '0; bus_b.rd_addr = '0;

    // Reset state.
    tick();
    half();
    check("rst_ready", bus_a.wb_ready, 3'b000);
    tick();
    reset_n = 1'b1;
    check("rst_rd_valid", bus_a.rd_valid, 2'b00);
    check("rst_rd_data", bus_a.rd_data, 64'h0);
    check("rst_cnt", bus_a.commit_count, 48'h0);

    for (int r = 1; r < NUM_REGS; r++) rd(1'b0, "rst_read", r, NUM_REGS - r, 32'h0, 32'h0);

    // NUM_WP=1, all three channels held valid: grants 0,1,2 in turn.
    wb_a(3'b111, {5'd5, 5'd4, 5'd3}, {32'hC, 32'hB, 32'hA});
    half(); check("rr_g0", bus_a.wb_ready, 3'b001); tick();
    half(); check("rr_g1", bus_a.wb_ready, 3'b010); tick();
    half(); check("rr_g2", bus_a.wb_ready, 3'b100); tick();
    wb_a('0, '0, '0);
    rd(1'b0, "rr_r34", 3, 4, 32'hA, 32'hB);
    rd(1'b0, "rr_r5", 5, 0, 32'hC, 32'h0);
    check("rr_cnt", bus_a.commit_count, {16'd1, 16'd1, 16'd1});

    // Continuous contention: every channel served once per three cycles.
    wb_a(3'b111, {5'd12, 5'd11, 5'd10}, {32'h3, 32'h2, 32'h1});
    for (int c = 0; c < 6; c++) begin
      half();
      check("starve", bus_a.wb_ready, 64'(3'b001 << (c % 3)));
      tick();
    end
    wb_a('0, '0, '0);
    rd(1'b0, "starve_r", 10, 12, 32'h1, 32'h3);
    rd(1'b0, "starve_r11", 11, 0, 32'h2, 32'h0);
    check("starve_cnt", bus_a.commit_count, {16'd3, 16'd3, 16'd3});

    // Dest 0: acknowledged and counted, never written.
    wb_a(3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFF, 32'h0, 32'h0});
    half(); check("d0_ready", bus_a.wb_ready, 3'b100); tick();
    wb_a('0, '0, '0);
    check("d0_cnt", bus_a.commit_count[47:32], 16'd4);
    rd(1'b0, "d0_read", 0, 0, 32'h0, 32'h0);

    // Same-edge commit and read of reg 9.
    wb_a(3'b100, {5'd9, 5'd0, 5'd0}, {32'h55, 32'h0, 32'h0});
    bus_a.rd_en = 2'b01; bus_a.rd_addr = {5'd0, 5'd9};
    half(); check("byp_ready", bus_a.wb_ready, 3'b100); tick();
    wb_a('0, '0, '0);
    bus_a.rd_en = '0;
    check("byp_vld", bus_a.rd_valid, 2'b01);
    check("byp_data", bus_a.rd_data[31:0], BYP_EXP);
    rd(1'b0, "byp_next", 9, 9, 32'h55, 32'h55);

    // Single write on ch1, moves the pointer to 2.
    wb_a(3'b010, {5'd0, 5'd13, 5'd0}, {32'h0, 32'h1313, 32'h0});
    half(); check("w13_ready", bus_a.wb_ready, 3'b010); tick();
    wb_a('0, '0, '0);
    rd(1'b0, "w13_read", 13, 0, 32'h1313, 32'h0);

    // ch1 blocked behind ch2, then reset mid-handshake.
    wb_a(3'b110, {5'd20, 5'd21, 5'd0}, {32'h77, 32'h88, 32'h0});
    half(); check("blk_ready", bus_a.wb_ready, 3'b100);
    reset_n = 1'b0;
    #1;
    check("blk_rst_ready", bus_a.wb_ready, 3'b000);
    tick();
    reset_n = 1'b1;
    wb_a('0, '0, '0);
    check("blk_cnt", bus_a.commit_count, 48'h0);
    rd(1'b0, "blk_r2021", 20, 21, 32'h0, 32'h0);
    rd(1'b0, "blk_r13_3", 13, 3, 32'h0, 32'h0);
    wb_a(3'b111, {5'd1, 5'd1, 5'd1}, {32'h1, 32'h1, 32'h1});
    half(); check("blk_ptr0", bus_a.wb_ready, 3'b001);
    wb_a('0, '0, '0);
    tick();

    // NUM_WP=2: same-destination collision serialises ch0 then ch1.
    wb_b(3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'h22, 32'h11});
    half(); check("wp2_c1", bus_b.wb_ready, 3'b001); tick();
    bus_b.wb_valid = 3'b010;
    half(); check("wp2_c2", bus_b.wb_ready, 3'b010); tick();
    wb_b('0, '0, '0);

    // Pointer now 2: scan 2,0 fills both slots, ch1 waits a cycle.
    wb_b(3'b111, {5'd3, 5'd2, 5'd1}, {32'h303, 32'h202, 32'h101});
    half(); check("wp2_dual", bus_b.wb_ready, 3'b101); tick();
    bus_b.wb_valid = 3'b010;
    half(); check("wp2_rest", bus_b.wb_ready, 3'b010); tick();
    wb_b('0, '0, '0);

    // Two dest-0 writes never collide.
    wb_b(3'b011, {5'd0, 5'd0, 5'd0}, {32'h0, 32'hBB, 32'hAA});
    half(); check("wp2_d0", bus_b.wb_ready, 3'b011); tick();
    wb_b('0, '0, '0);

    rd(1'b1, "wp2_r71", 7, 1, 32'h22, 32'h101);
    rd(1'b1, "wp2_r23", 2, 3, 32'h202, 32'h303);
    rd(1'b1, "wp2_r0", 0, 0, 32'h0, 32'h0);
    check("wp2_cnt", bus_b.commit_count, {16'd1, 16'd3, 16'd3});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_multiport_wb.md
# regfile_multiport_wb

Parametrised register file for the out-of-order core. It accepts results from NUM_WB functional-unit writeback channels through valid/ready handshakes and arbitrates among them round-robin. Up to NUM_WP results are committed per cycle, and NUM_RD registered read ports serve the dispatch unit. It replaces the fixed three-source, one-write-per-cycle register file, which used ad-hoc enable/reset-flag handshakes.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count; register 0 is hardwired to zero; ADDR_W = $clog2(NUM_REGS)
- NUM_WB, 3, writeback channels (e.g. adder, multiplier, memory), index 0..NUM_WB-1
- NUM_WP, 1, maximum commits per cycle, 1 ≤ NUM_WP ≤ NUM_WB
- NUM_RD, 2, read ports

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  synchronous, active-low reset
- wb_valid  in  NUM_WB  channel i holds a result
- wb_dest  in  NUM_WB*ADDR_W  destination of channel i, slice [i*ADDR_W +: ADDR_W]
- wb_data  in  NUM_WB*DATA_W  result of channel i
- wb_ready  out  NUM_WB  combinational grant; transfer of channel i = wb_valid[i] & wb_ready[i]
- rd_en  in  NUM_RD  read request per port
- rd_addr  in  NUM_RD*ADDR_W  read address per port
- rd_data  out  NUM_RD*DATA_W  registered read data
- rd_valid  out  NUM_RD  one-cycle pulse, rd_data is valid
- commit_count  out  NUM_WB*16  per-channel saturating count of committed results

## Operation
- Reset (reset_n=0 at edge): all registers 0, rd_data 0, rd_valid 0, commit_count 0, round-robin pointer 0. wb_ready is 0 while reset_n=0.
- Arbitration: scan channels from pointer p upward, wrapping. Grant up to NUM_WP channels with wb_valid=1.
  - A channel whose wb_dest equals the dest of an already-granted channel this cycle is skipped (not ready) and waits.
  - Exception: dest 0 is never skipped for this reason.
- Commit: each transfer writes wb_data to registers[wb_dest] at the edge. A transfer with dest 0 is acknowledged but not written, and still counts.
- Pointer: if ≥1 grant, p ← (last granted index + 1) mod NUM_WB; otherwise unchanged.
- Sources hold wb_valid/dest/data stable until the transfer. wb_ready may depend on wb_valid of other channels but not on wb_data.
- Read: when rd_en[k]=1, rd_data[k] ← registers[rd_addr[k]] at the edge and rd_valid[k] ← 1. Otherwise rd_valid[k] ← 0 and rd_data[k] holds.
- Address 0 always reads 0. Addresses ≥ NUM_REGS read 0 and writes to them are discarded (still acknowledged).
- commit_count[i] increments by 1 per transfer and saturates at 16'hFFFF.

## Timing
- Write latency: a transfer in cycle n is visible to a read issued in cycle n+1.
- Read latency: 1 cycle (rd_en at edge n, rd_data/rd_valid after edge n).
- Read and commit to the same address in the same cycle: resolved per Configuration.
- All valid, NUM_WP=1: each channel granted once every NUM_WB cycles (starvation-free).
- reset_n deasserted mid-handshake: no transfer occurs in the reset cycle. Sources must re-present after reset.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches a commit on the same edge returns the committed data. If several commits target it, only dest 0 can coincide, and address 0 still returns 0.
- REGFILE_BYPASS_EN undefined: that read returns the pre-commit value; the new value is visible from the next read.

## Test plan
- Reset → read regs 1..31 on both ports: all return 0, rd_valid pulses 1 cycle after rd_en, commit_count all 0.
- NUM_WP=1, all three channels valid continuously with dest 3/4/5 and data 0xA/0xB/0xC → grants 0,1,2 in consecutive cycles. Registers 3/4/5 = 0xA/0xB/0xC, commit_count = 1 each.
- NUM_WP=2, channels 0 and 1 both dest 7, data 0x11/0x22, p=0 → cycle 1 grants ch0 only; cycle 2 grants ch1; reg 7 ends 0x22.
- Channel 2 writes dest 0 data 0xFFFF → wb_ready=1, commit_count[2] increments, reading reg 0 returns 0.
- Same-cycle commit reg 9 = 0x55 and read reg 9 (old value 0) → rd_data 0x55 with REGFILE_BYPASS_EN, 0 without it. The next read returns 0x55 in both builds.
- Assert reset_n=0 while ch1 is valid and blocked → wb_ready=0, no register change, pointer 0 after release.
